// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: START -> PLAY with pause, level-clear and life-lost
// interludes, ending in GAME_OVER or YOU_WIN. All outputs come straight from flops.
module game_flow_ctrl #(
   parameter  int NUM_LEVELS   = 3,
   parameter  int NUM_LIVES    = 3,
   parameter  int TRANS_CYCLES = 120,
   localparam int LW           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
   localparam int VW           = $clog2(NUM_LIVES + 1),
   localparam int TW           = $clog2(TRANS_CYCLES + 1)
) (
   input  logic          Clk,
   input  logic          reset_n,
   input  logic          Run,
   input  logic          Pause,
   input  logic          Win,
   input  logic          loss,
   input  logic          Restart,
   output logic [2:0]    state,
   output logic [LW-1:0] level,
   output logic [VW-1:0] lives,
   output logic          freeze,
   output logic          level_load,
   output logic          respawn
);

   typedef enum logic [2:0] {
      S_START       = 3'b000,
      S_PLAY        = 3'b001,
      S_PAUSED      = 3'b010,
      S_LEVEL_CLEAR = 3'b011,
      S_LIFE_LOST   = 3'b100,
      S_GAME_OVER   = 3'b101,
      S_YOU_WIN     = 3'b110,
      S_ILLEGAL     = 3'b111
   } state_e;

   localparam logic [LW-1:0] LAST_LVL   = LW'(NUM_LEVELS - 1);
   localparam logic [VW-1:0] LIVES_INIT = VW'(NUM_LIVES);
   localparam logic [TW-1:0] TIMER_INIT = TW'(TRANS_CYCLES - 1);

   state_e        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic [VW-1:0] lives_q, lives_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          freeze_q, freeze_d;
   logic          level_load_q, level_load_d;
   logic          respawn_q, respawn_d;

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_START;
         level_q      <= '0;
         lives_q      <= LIVES_INIT;
         timer_q      <= '0;
         freeze_q     <= 1'b1;
         level_load_q <= 1'b0;
         respawn_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         lives_q      <= lives_d;
         timer_q      <= timer_d;
         freeze_q     <= freeze_d;
         level_load_q <= level_load_d;
         respawn_q    <= respawn_d;
      end
   end

   // Win outranks loss, which outranks Pause, when they coincide in PLAY.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lives_d = lives_q;
      timer_d = timer_q;
      case (state_q)
         S_START: begin
            if (Run) begin
               state_d = S_PLAY;
               level_d = '0;
               lives_d = LIVES_INIT;
               timer_d = '0;
            end
         end
         S_PLAY: begin
            if (Win) begin
               if (level_q >= LAST_LVL) begin
                  state_d = S_YOU_WIN;
               end else begin
                  state_d = S_LEVEL_CLEAR;
                  timer_d = TIMER_INIT;
               end
            end else if (loss) begin
               if (lives_q <= VW'(1)) begin
                  lives_d = '0;
                  state_d = S_GAME_OVER;
               end else begin
                  lives_d = lives_q - VW'(1);
                  state_d = S_LIFE_LOST;
                  timer_d = TIMER_INIT;
               end
            end else if (Pause) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (Pause) state_d = S_PLAY;
         end
         S_LEVEL_CLEAR: begin
            if (timer_q == '0) begin
               state_d = S_PLAY;
               if (level_q < LAST_LVL) level_d = level_q + LW'(1);
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_LIFE_LOST: begin
            if (timer_q == '0) state_d = S_PLAY;
            else               timer_d = timer_q - TW'(1);
         end
         S_GAME_OVER, S_YOU_WIN: begin
            if (Restart) state_d = S_START;
         end
         default: state_d = S_START;
      endcase
   end

   // Pulses are decoded from the transition so they land in the first cycle of PLAY.
   always_comb begin
      freeze_d     = (state_d != S_PLAY);
      level_load_d = (state_d == S_PLAY) &&
                     ((state_q == S_START) || (state_q == S_LEVEL_CLEAR));
      respawn_d    = (state_d == S_PLAY) && (state_q == S_LIFE_LOST);
   end

   assign state      = state_q;
   assign level      = level_q;
   assign lives      = lives_q;
   assign freeze     = freeze_q;
   assign level_load = level_load_q;
   assign respawn    = respawn_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a 3-level/3-life/4-cycle instance and a
// 1-level/1-life/1-cycle instance share stimulus; inputs change and outputs are sampled on negedge.
module tb_game_flow_ctrl;

   logic       Clk, reset_n, Run, Pause, Win, loss, Restart;
   logic [2:0] st,  st1;
   logic [1:0] lvl, lv;
   logic [0:0] lvl1, lv1;
   logic       frz, ll, rs, frz1, ll1, rs1;
   int         tests = 0;
   int         fails = 0;

   game_flow_ctrl #(.NUM_LEVELS(3), .NUM_LIVES(3), .TRANS_CYCLES(4)) dut (
      .Clk(Clk), .reset_n(reset_n), .Run(Run), .Pause(Pause), .Win(Win), .loss(loss),
      .Restart(Restart), .state(st), .level(lvl), .lives(lv), .freeze(frz),
      .level_load(ll), .respawn(rs));

   game_flow_ctrl #(.NUM_LEVELS(1), .NUM_LIVES(1), .TRANS_CYCLES(1)) dut1 (
      .Clk(Clk), .reset_n(reset_n), .Run(Run), .Pause(Pause), .Win(Win), .loss(loss),
      .Restart(Restart), .state(st1), .level(lvl1), .lives(lv1), .freeze(frz1),
      .level_load(ll1), .respawn(rs1));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "timeout");
   end

   task automatic pulse_run();     Run = 1'b1;     @(negedge Clk); Run = 1'b0;     endtask
   task automatic pulse_win();     Win = 1'b1;     @(negedge Clk); Win = 1'b0;     endtask
   task automatic pulse_loss();    loss = 1'b1;    @(negedge Clk); loss = 1'b0;    endtask
   task automatic pulse_pause();   Pause = 1'b1;   @(negedge Clk); Pause = 1'b0;   endtask
   task automatic pulse_restart(); Restart = 1'b1; @(negedge Clk); Restart = 1'b0; endtask

   task automatic test_reset();
      reset_n = 1'b0; Run = 0; Pause = 0; Win = 0; loss = 0; Restart = 0;
      repeat (2) @(negedge Clk);
      tests++; if (st !== 3'd0) begin fails++; $display("FAIL rst_state got %0d want 0", st); end
      tests++; if (lvl !== 2'd0) begin fails++; $display("FAIL rst_level got %0d want 0", lvl); end
      tests++; if (lv !== 2'd3) begin fails++; $display("FAIL rst_lives got %0d want 3", lv); end
      tests++; if (frz !== 1'b1) begin fails++; $display("FAIL rst_freeze got %0b want 1", frz); end
      tests++; if (ll !== 1'b0 || rs !== 1'b0) begin fails++; $display("FAIL rst_pulses got ll=%0b rs=%0b want 0/0", ll, rs); end
      reset_n = 1'b1;
      @(negedge Clk);
      tests++; if (st !== 3'd0) begin fails++; $display("FAIL idle_start got %0d want 0", st); end
   endtask

   task automatic test_start();
      pulse_run();
      tests++; if (st !== 3'd1) begin fails++; $display("FAIL start_state got %0d want 1", st); end
      tests++; if (lvl !== 2'd0 || lv !== 2'd3) begin fails++; $display("FAIL start_lvl_lives got %0d/%0d want 0/3", lvl, lv); end
      tests++; if (ll !== 1'b1 || frz !== 1'b0 || rs !== 1'b0) begin fails++; $display("FAIL start_outs got ll=%0b frz=%0b rs=%0b want 1/0/0", ll, frz, rs); end
      @(negedge Clk);
      tests++; if (ll !== 1'b0 || st !== 3'd1) begin fails++; $display("FAIL start_ll_once got ll=%0b st=%0d want 0/1", ll, st); end
   endtask

   task automatic test_level_clear();
      logic [1:0] exp_lvl;
      for (int l = 0; l < 2; l++) begin
         exp_lvl = 2'(l + 1);
         pulse_win();
         for (int c = 0; c < 4; c++) begin
            tests++; if (st !== 3'd3 || frz !== 1'b1) begin fails++; $display("FAIL clr_dwell c=%0d got st=%0d frz=%0b want 3/1", c, st, frz); end
            @(negedge Clk);
         end
         tests++; if (st !== 3'd1 || lvl !== exp_lvl) begin fails++; $display("FAIL clr_exit got st=%0d lvl=%0d want 1/%0d", st, lvl, exp_lvl); end
         tests++; if (ll !== 1'b1 || rs !== 1'b0) begin fails++; $display("FAIL clr_load got ll=%0b rs=%0b want 1/0", ll, rs); end
         @(negedge Clk);
         tests++; if (ll !== 1'b0) begin fails++; $display("FAIL clr_load_once got %0b want 0", ll); end
      end
      pulse_win();
      tests++; if (st !== 3'd6 || lvl !== 2'd2) begin fails++; $display("FAIL you_win got st=%0d lvl=%0d want 6/2", st, lvl); end
      repeat (2) @(negedge Clk);
      tests++; if (st !== 3'd6 || ll !== 1'b0) begin fails++; $display("FAIL win_hold got st=%0d ll=%0b want 6/0", st, ll); end
      pulse_restart();
      tests++; if (st !== 3'd0 || lvl !== 2'd2) begin fails++; $display("FAIL win_restart got st=%0d lvl=%0d want 0/2", st, lvl); end
   endtask

   task automatic test_loss();
      logic [1:0] exp_lv;
      pulse_run();
      tests++; if (st !== 3'd1 || lv !== 2'd3 || lvl !== 2'd0) begin fails++; $display("FAIL loss_start got st=%0d lv=%0d lvl=%0d want 1/3/0", st, lv, lvl); end
      for (int k = 0; k < 2; k++) begin
         exp_lv = 2'(2 - k);
         pulse_loss();
         tests++; if (st !== 3'd4 || lv !== exp_lv) begin fails++; $display("FAIL loss_enter got st=%0d lv=%0d want 4/%0d", st, lv, exp_lv); end
         repeat (3) @(negedge Clk);
         tests++; if (st !== 3'd4) begin fails++; $display("FAIL loss_dwell got %0d want 4", st); end
         @(negedge Clk);
         tests++; if (st !== 3'd1 || rs !== 1'b1 || ll !== 1'b0 || lvl !== 2'd0) begin fails++; $display("FAIL loss_respawn got st=%0d rs=%0b ll=%0b lvl=%0d want 1/1/0/0", st, rs, ll, lvl); end
         @(negedge Clk);
         tests++; if (rs !== 1'b0) begin fails++; $display("FAIL respawn_once got %0b want 0", rs); end
      end
      pulse_loss();
      tests++; if (st !== 3'd5 || lv !== 2'd0) begin fails++; $display("FAIL game_over got st=%0d lv=%0d want 5/0", st, lv); end
      pulse_restart();
      tests++; if (st !== 3'd0 || lv !== 2'd0) begin fails++; $display("FAIL over_restart got st=%0d lv=%0d want 0/0", st, lv); end
   endtask

   task automatic test_priority();
      pulse_run();
      Win = 1'b1; loss = 1'b1; Pause = 1'b1;
      @(negedge Clk);
      Win = 1'b0; loss = 1'b0; Pause = 1'b0;
      tests++; if (st !== 3'd3 || lv !== 2'd3) begin fails++; $display("FAIL prio_win got st=%0d lv=%0d want 3/3", st, lv); end
      repeat (4) @(negedge Clk);
      tests++; if (st !== 3'd1 || lvl !== 2'd1) begin fails++; $display("FAIL prio_exit got st=%0d lvl=%0d want 1/1", st, lvl); end
      pulse_pause();
      tests++; if (st !== 3'd2 || frz !== 1'b1) begin fails++; $display("FAIL pause_enter got st=%0d frz=%0b want 2/1", st, frz); end
      pulse_loss();
      tests++; if (st !== 3'd2 || lv !== 2'd3) begin fails++; $display("FAIL pause_loss got st=%0d lv=%0d want 2/3", st, lv); end
      pulse_win();
      tests++; if (st !== 3'd2 || lvl !== 2'd1) begin fails++; $display("FAIL pause_win got st=%0d lvl=%0d want 2/1", st, lvl); end
      pulse_pause();
      tests++; if (st !== 3'd1 || frz !== 1'b0 || ll !== 1'b0) begin fails++; $display("FAIL pause_exit got st=%0d frz=%0b ll=%0b want 1/0/0", st, frz, ll); end
   endtask

   task automatic test_async_reset();
      pulse_win();
      @(negedge Clk);
      #2 reset_n = 1'b0;
      #1;
      tests++; if (st !== 3'd0 || lvl !== 2'd0 || lv !== 2'd3) begin fails++; $display("FAIL areset_vals got st=%0d lvl=%0d lv=%0d want 0/0/3", st, lvl, lv); end
      tests++; if (frz !== 1'b1 || ll !== 1'b0 || rs !== 1'b0) begin fails++; $display("FAIL areset_outs got frz=%0b ll=%0b rs=%0b want 1/0/0", frz, ll, rs); end
      @(negedge Clk);
      reset_n = 1'b1;
      repeat (5) begin
         @(negedge Clk);
         tests++; if (st !== 3'd0 || ll !== 1'b0) begin fails++; $display("FAIL areset_after got st=%0d ll=%0b want 0/0", st, ll); end
      end
   endtask

   task automatic test_small_cfg();
      reset_n = 1'b0;
      @(negedge Clk);
      reset_n = 1'b1;
      @(negedge Clk);
      pulse_run();
      tests++; if (st1 !== 3'd1 || lv1 !== 1'b1 || ll1 !== 1'b1 || lvl1 !== 1'b0) begin fails++; $display("FAIL small_start got st=%0d lv=%0d ll=%0b lvl=%0d want 1/1/1/0", st1, lv1, ll1, lvl1); end
      pulse_win();
      tests++; if (st1 !== 3'd6 || ll1 !== 1'b0) begin fails++; $display("FAIL small_win got st=%0d ll=%0b want 6/0", st1, ll1); end
      pulse_restart();
      tests++; if (st1 !== 3'd0) begin fails++; $display("FAIL small_restart got %0d want 0", st1); end
      pulse_run();
      pulse_loss();
      tests++; if (st1 !== 3'd5 || lv1 !== 1'b0 || rs1 !== 1'b0) begin fails++; $display("FAIL small_loss got st=%0d lv=%0d rs=%0b want 5/0/0", st1, lv1, rs1); end
      pulse_restart();
      tests++; if (st1 !== 3'd0) begin fails++; $display("FAIL small_restart2 got %0d want 0", st1); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_level_clear();
      test_loss();
      test_priority();
      test_async_reset();
      test_small_cfg();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
